// File: rtl/interval_timer_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : interval_timer_ctrl_if
//  Purpose  : Configuration / control / status bundle for interval_timer_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
interface interval_timer_ctrl_if #(
    parameter int N = 8
) ();
    logic         cfg_valid;
    logic         cfg_ready;
    logic [N-1:0] cfg_period;
    logic         cfg_mode;
    logic         start;
    logic         stop;
    logic         busy;
    logic [N-1:0] count;
    logic         expire;
    logic [1:0]   state;

    modport master (
        output cfg_valid, cfg_period, cfg_mode, start, stop,
        input  cfg_ready, busy, count, expire, state
    );

    modport slave (
        input  cfg_valid, cfg_period, cfg_mode, start, stop,
        output cfg_ready, busy, count, expire, state
    );
endinterface
`default_nettype wire

// File: rtl/interval_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : interval_timer_ctrl
//  Purpose  : One-shot / periodic interval timer with a down-counter and a
//             registered expire pulse. Define INTERVAL_TIMER_CTRL_PRESCALE_EN
//             to divide the tick rate by 2**PS.
//  Revision : 1.0  initial release
// ============================================================================
module interval_timer_ctrl #(
    parameter int N  = 8,
    parameter int PS = 2
) (
    input  wire logic clk,
    input  wire logic reset_n,
    interval_timer_ctrl_if.slave tmr
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_DONE    = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

    state_t       state_q,  state_d;
    logic [N-1:0] count_q,  count_d;
    logic [N-1:0] period_q, period_d;
    logic         mode_q,   mode_d;
    logic         expire_q, expire_d;

    logic         w_cfg_ready;
    logic         w_cfg_accept;
    logic [N-1:0] w_eff_period;
    logic         w_start_ok;
    logic         w_tick;

    assign w_cfg_ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign w_cfg_accept = tmr.cfg_valid && w_cfg_ready;
    // A period offered alongside start takes effect for that very start.
    assign w_eff_period = w_cfg_accept ? tmr.cfg_period : period_q;
    assign w_start_ok   = tmr.start && (w_eff_period != '0);

`ifdef INTERVAL_TIMER_CTRL_PRESCALE_EN
    logic [PS-1:0] psc_q, psc_d;

    assign w_tick = (psc_q == {PS{1'b1}});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end
`else
    assign w_tick = 1'b1;

    // PS only sizes the prescaler, which is absent in this build.
    if (PS < 1) begin : g_ps_unused
    end
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        period_d = period_q;
        mode_d   = mode_q;
        expire_d = 1'b0;
`ifdef INTERVAL_TIMER_CTRL_PRESCALE_EN
        psc_d    = psc_q;
`endif

        if (w_cfg_accept) begin
            period_d = tmr.cfg_period;
            mode_d   = tmr.cfg_mode;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (tmr.stop) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (w_start_ok) begin
                    state_d = ST_RUN;
                    count_d = w_eff_period;
`ifdef INTERVAL_TIMER_CTRL_PRESCALE_EN
                    psc_d   = '0;
`endif
                end
            end

            ST_RUN: begin
`ifdef INTERVAL_TIMER_CTRL_PRESCALE_EN
                psc_d = psc_q + 1'b1;
`endif
                if (tmr.stop) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (w_tick) begin
                    if (count_q == N'(1)) begin
                        expire_d = 1'b1;
                        if (mode_q) begin
                            count_d = period_q;
`ifdef INTERVAL_TIMER_CTRL_PRESCALE_EN
                            psc_d   = '0;
`endif
                        end else begin
                            count_d = '0;
                            state_d = ST_DONE;
                        end
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            period_q <= '0;
            mode_q   <= 1'b0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            expire_q <= expire_d;
        end
    end

    assign tmr.cfg_ready = w_cfg_ready;
    assign tmr.busy      = (state_q == ST_RUN);
    assign tmr.count     = count_q;
    assign tmr.expire    = expire_q;
    assign tmr.state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_interval_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_interval_timer_ctrl
//  Purpose  : Scoreboard bench for interval_timer_ctrl; the reference model
//             derives count/expire from time elapsed since start.
//  Revision : 1.0  initial release
// ============================================================================
module tb_interval_timer_ctrl;
    localparam int N  = 8;
    localparam int PS = 2;
`ifdef INTERVAL_TIMER_CTRL_PRESCALE_EN
    localparam int S = 1 << PS;
`else
    localparam int S = 1;
`endif

    typedef struct {
        int st;
        int cnt;
        bit expv;
        bit busy;
        bit rdy;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    exp_t sb[$];

    // model state: 0 idle, 1 run, 2 done
    int m_st   = 0;
    int m_per  = 0;
    int m_mode = 0;
    int t0     = 0;
    int cyc    = 0;

    interval_timer_ctrl_if #(.N(N)) bus ();

    interval_timer_ctrl #(.N(N), .PS(PS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .tmr     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock edge of the reference model, using the inputs sampled there.
    task automatic model_step(input bit rst_low);
        exp_t e;
        int   el;
        bit   expv;
        expv = 1'b0;
        cyc++;
        if (rst_low) begin
            m_st   = 0;
            m_per  = 0;
            m_mode = 0;
        end else begin
            if (bus.cfg_valid && m_st != 1) begin
                m_per  = int'(bus.cfg_period);
                m_mode = int'(bus.cfg_mode);
            end
            if (bus.stop) begin
                m_st = 0;
            end else if (m_st != 1 && bus.start && m_per != 0) begin
                m_st = 1;
                t0   = cyc;
            end else if (m_st == 1) begin
                el = cyc - t0;
                if (el % S == 0 && (el / S) % m_per == 0) begin
                    expv = 1'b1;
                    if (m_mode == 0) m_st = 2;
                end
            end
        end
        e.st   = m_st;
        e.expv = expv;
        e.busy = (m_st == 1);
        e.rdy  = (m_st != 1);
        e.cnt  = (m_st == 1) ? m_per - (((cyc - t0) / S) % m_per) : 0;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(!reset_n);
        #1;
    endtask

    task automatic drv(input bit v, input int p, input bit m, input bit st, input bit sp);
        bus.cfg_valid  = v;
        bus.cfg_period = N'(p);
        bus.cfg_mode   = m;
        bus.start      = st;
        bus.stop       = sp;
    endtask

    task automatic async_reset();
        @(posedge clk);
        model_step(1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_state",  32'(bus.state),     0);
        chk("arst_count",  32'(bus.count),     0);
        chk("arst_busy",   32'(bus.busy),      0);
        chk("arst_expire", 32'(bus.expire),    0);
        chk("arst_ready",  32'(bus.cfg_ready), 1);
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Monitor: every cycle the DUT presents a status word; compare at negedge.
    initial begin
        exp_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow actual=0 required=1 entries (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                chk("state",     32'(bus.state),     32'(e.st));
                chk("count",     32'(bus.count),     32'(e.cnt));
                chk("expire",    32'(bus.expire),    32'(e.expv));
                chk("busy",      32'(bus.busy),      32'(e.busy));
                chk("cfg_ready", 32'(bus.cfg_ready), 32'(e.rdy));
            end
        end
    end

    initial begin
        drv(0, 0, 0, 0, 0);
        repeat (3) tick();
        reset_n = 1'b1;

        // start before any configuration
        drv(0, 0, 0, 1, 0); tick();
        drv(0, 0, 0, 0, 0); tick();

        // one-shot P=5, configured then started
        drv(1, 5, 0, 0, 0); tick();
        drv(0, 0, 0, 1, 0); tick();
        drv(0, 0, 0, 0, 0); repeat (6 * S + 2) tick();

        // periodic P=3 configured with start in the same cycle
        drv(1, 3, 1, 1, 0); tick();
        drv(0, 0, 0, 0, 0); repeat (10 * S) tick();
        // cfg and start during RUN are ignored
        drv(1, 7, 0, 1, 0); tick();
        drv(0, 0, 0, 0, 0); repeat (4 * S) tick();
        drv(0, 0, 0, 0, 1); tick();
        drv(0, 0, 0, 0, 0); tick();

        // zero period
        drv(1, 0, 0, 0, 0); tick();
        drv(0, 0, 0, 1, 0); tick();
        drv(0, 0, 0, 0, 0); repeat (3) tick();

        // stop+start on the expiry edge, then restart with the old period
        drv(1, 4, 0, 1, 0); tick();
        drv(0, 0, 0, 0, 0); repeat (4 * S - 1) tick();
        drv(0, 0, 0, 1, 1); tick();
        drv(0, 0, 0, 0, 0); tick();
        drv(0, 0, 0, 1, 0); tick();
        drv(0, 0, 0, 0, 0); repeat (5 * S) tick();

        // periodic P=2, then async reset mid-RUN
        drv(1, 2, 1, 1, 0); tick();
        drv(0, 0, 0, 0, 0); repeat (5 * S) tick();
        drv(1, 6, 1, 1, 0); tick();
        drv(0, 0, 0, 0, 0); repeat (3) tick();
        async_reset();
        drv(0, 0, 0, 1, 0); tick();
        drv(0, 0, 0, 0, 0); repeat (2) tick();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                drv(0, 0, 0, 0, 0);
                async_reset();
            end else begin
                drv($urandom_range(0, 5) == 0, int'($urandom_range(0, 6)),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 19) == 0);
                tick();
            end
        end

        drv(0, 0, 0, 0, 0);
        tick();
        @(negedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
